// File: rtl/gpio_port.sv
// gpio_port: WIDTH-bit bidirectional GPIO with atomic output ops, synchronised input and sticky W1C edge flags.
// Define GPIO_DEBOUNCE_EN to insert a per-bit debounce filter between the synchroniser and inData.
module gpio_port #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cePortDir,
  input  logic [WIDTH-1:0] portDir,
  input  logic             cePortOut,
  input  logic [1:0]       outOp,
  input  logic [WIDTH-1:0] portData,
  input  logic             ceIrqCfg,
  input  logic [WIDTH-1:0] irqRise,
  input  logic [WIDTH-1:0] irqFall,
  input  logic             ceIrqClr,
  input  logic [WIDTH-1:0] irqClr,
  inout  wire  [WIDTH-1:0] pad,
  output logic [WIDTH-1:0] inData,
  output logic [WIDTH-1:0] irqFlags,
  output logic             irq
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("gpio_port: SYNC_STAGES must be 2..4");
  end
  if (DB_CYCLES < 2) begin : g_bad_db
    $error("gpio_port: DB_CYCLES must be >= 2");
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int PRIME_MAX = SYNC_STAGES + 1 + DB_CYCLES;
`else
  localparam int PRIME_MAX = SYNC_STAGES + 1;
`endif
  localparam int PW = $clog2(PRIME_MAX + 1);

  logic [WIDTH-1:0] dir_q, out_q, out_d;
  logic [WIDTH-1:0] rise_mask_q, fall_mask_q;
  logic [WIDTH-1:0] flags_q, flags_d;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] rise_w, fall_w, set_w;
  logic [PW-1:0]    prime_q;
  logic             primed;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pad
    assign pad[i] = dir_q[i] ? out_q[i] : 1'bz;
  end

  // The pad is sampled as resolved, so output bits read back their driven level.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= pad;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_TOP = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ARM = CW'(DB_CYCLES - 2);

  logic [CW-1:0]    db_cnt_q [WIDTH];
  logic [WIDTH-1:0] cand_q;
  logic [WIDTH-1:0] db_q;

  // inData loads on the edge where the counter reaches CNT_TOP, i.e. after DB_CYCLES stable samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand_q <= '0;
      db_q   <= '0;
      for (int i = 0; i < WIDTH; i++) db_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_out[i] != cand_q[i]) begin
          cand_q[i]   <= sync_out[i];
          db_cnt_q[i] <= '0;
        end else begin
          if (db_cnt_q[i] != CNT_TOP) db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
          if ((db_cnt_q[i] >= CNT_ARM) && (cand_q[i] != db_q[i])) db_q[i] <= cand_q[i];
        end
      end
    end
  end

  assign in_data = db_q;
`else
  assign in_data = sync_out;
`endif

  assign primed = (prime_q == PW'(PRIME_MAX));

  always_comb begin
    out_d = out_q;
    if (cePortOut) begin
      case (outOp)
        2'b00:   out_d = portData;
        2'b01:   out_d = out_q | portData;
        2'b10:   out_d = out_q & ~portData;
        default: out_d = out_q ^ portData;
      endcase
    end
  end

  // Set is OR'd in after the clear so a coincident edge keeps its flag.
  always_comb begin
    rise_w  = in_data & ~prev_q;
    fall_w  = ~in_data & prev_q;
    set_w   = primed ? ((rise_w & rise_mask_q) | (fall_w & fall_mask_q)) : '0;
    flags_d = (flags_q & ~(ceIrqClr ? irqClr : '0)) | set_w;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q       <= '0;
      out_q       <= '0;
      rise_mask_q <= '0;
      fall_mask_q <= '0;
      flags_q     <= '0;
      prev_q      <= '0;
      prime_q     <= '0;
    end else begin
      if (cePortDir) dir_q <= portDir;
      out_q <= out_d;
      if (ceIrqCfg) begin
        rise_mask_q <= irqRise;
        fall_mask_q <= irqFall;
      end
      flags_q <= flags_d;
      prev_q  <= in_data;
      if (!primed) prime_q <= prime_q + 1'b1;
    end
  end

  assign inData   = in_data;
  assign irqFlags = flags_q;
  assign irq      = |flags_q;

endmodule

// File: tb/tb_gpio_port.sv
// tb_gpio_port: directed checks of gpio_port output ops, direction, edge flags, priming and reset.
// The debounce scenario is compiled in only when GPIO_DEBOUNCE_EN is defined.
module tb_gpio_port;
  localparam int SS = 2;
  localparam int DB = 8;
`ifdef GPIO_DEBOUNCE_EN
  localparam int LAT = SS + DB;
`else
  localparam int LAT = SS;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cePortDir = 1'b0, cePortOut = 1'b0, ceIrqCfg = 1'b0, ceIrqClr = 1'b0;
  logic [7:0] portDir = '0, portData = '0, irqRise = '0, irqFall = '0, irqClr = '0;
  logic [1:0] outOp = '0;
  logic [7:0] ext_en = 8'hFF, ext_val = 8'h5A;
  wire  [7:0] pad;
  logic [7:0] inData, irqFlags;
  logic       irq;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 8; i++) begin : g_ext
    assign pad[i] = ext_en[i] ? ext_val[i] : 1'bz;
  end

  gpio_port #(.WIDTH(8), .SYNC_STAGES(SS), .DB_CYCLES(DB)) dut (
    .clk(clk), .rst(rst),
    .cePortDir(cePortDir), .portDir(portDir),
    .cePortOut(cePortOut), .outOp(outOp), .portData(portData),
    .ceIrqCfg(ceIrqCfg), .irqRise(irqRise), .irqFall(irqFall),
    .ceIrqClr(ceIrqClr), .irqClr(irqClr),
    .pad(pad), .inData(inData), .irqFlags(irqFlags), .irq(irq)
  );

  // Stimulus and checks both happen at the falling edge: check first, then drive.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr_dir(input logic [7:0] v);
    cePortDir = 1'b1; portDir = v;
    @(negedge clk);
    cePortDir = 1'b0;
  endtask

  task automatic wr_out(input logic [1:0] op, input logic [7:0] d);
    cePortOut = 1'b1; outOp = op; portData = d;
    @(negedge clk);
    cePortOut = 1'b0;
  endtask

  task automatic wr_cfg(input logic [7:0] r, input logic [7:0] f);
    ceIrqCfg = 1'b1; irqRise = r; irqFall = f;
    @(negedge clk);
    ceIrqCfg = 1'b0;
  endtask

  task automatic clr(input logic [7:0] m);
    ceIrqClr = 1'b1; irqClr = m;
    @(negedge clk);
    ceIrqClr = 1'b0; irqClr = '0;
  endtask

  task automatic test_reset;
    cyc(3);
    n_tests++; if (pad !== 8'h5A) begin n_fail++; $display("FAIL reset_pad: got %h exp 5a", pad); end
    n_tests++; if (inData !== 8'h00) begin n_fail++; $display("FAIL reset_indata: got %h exp 00", inData); end
    n_tests++; if (irqFlags !== 8'h00) begin n_fail++; $display("FAIL reset_flags: got %h exp 00", irqFlags); end
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b exp 0", irq); end
    ext_val = 8'h00;
    rst = 1'b0;
    cyc(1);
  endtask

  task automatic test_write_ops;
    wr_dir(8'hFF);
    ext_en = 8'h00;
    wr_out(2'b00, 8'hA5);
    n_tests++; if (pad !== 8'hA5) begin n_fail++; $display("FAIL op_write: got %h exp a5", pad); end
    wr_out(2'b01, 8'h0A);
    n_tests++; if (pad !== 8'hAF) begin n_fail++; $display("FAIL op_set: got %h exp af", pad); end
    wr_out(2'b10, 8'h05);
    n_tests++; if (pad !== 8'hAA) begin n_fail++; $display("FAIL op_clear: got %h exp aa", pad); end
    wr_out(2'b11, 8'hFF);
    n_tests++; if (pad !== 8'h55) begin n_fail++; $display("FAIL op_toggle: got %h exp 55", pad); end
    cyc(LAT);
    n_tests++; if (inData !== 8'h55) begin n_fail++; $display("FAIL readback: got %h exp 55", inData); end
  endtask

  task automatic test_direction;
    // External driver matches the DUT level on bits about to become inputs.
    ext_val = 8'h50; ext_en = 8'hF0;
    cePortDir = 1'b1; portDir = 8'h0F; cePortOut = 1'b1; outOp = 2'b00; portData = 8'hFF;
    @(negedge clk);
    cePortDir = 1'b0; cePortOut = 1'b0;
    n_tests++; if (pad !== 8'h5F) begin n_fail++; $display("FAIL dir_same_cycle: got %h exp 5f", pad); end
    ext_val = 8'h00;
    cyc(1);
    n_tests++; if (pad !== 8'h0F) begin n_fail++; $display("FAIL dir_hi_z: got %h exp 0f", pad); end
    cyc(LAT);
    n_tests++; if (inData !== 8'h0F) begin n_fail++; $display("FAIL dir_indata: got %h exp 0f", inData); end
    ext_en = 8'hFF; ext_val = 8'h0F;
    cePortDir = 1'b1; portDir = 8'h00; cePortOut = 1'b1; outOp = 2'b00; portData = 8'h3C;
    @(negedge clk);
    cePortDir = 1'b0; cePortOut = 1'b0;
    ext_val = 8'hC3;
    cyc(1);
    n_tests++; if (pad !== 8'hC3) begin n_fail++; $display("FAIL dir_all_z: got %h exp c3", pad); end
    ext_val = 8'h3C;
    wr_dir(8'hFF);
    ext_en = 8'h00;
    cyc(1);
    n_tests++; if (pad !== 8'h3C) begin n_fail++; $display("FAIL dir_retained: got %h exp 3c", pad); end
  endtask

  task automatic test_rise_irq;
    ext_en = 8'hFF; ext_val = 8'h3C;
    wr_dir(8'h00);
    ext_val = 8'h00;
    wr_cfg(8'h01, 8'h00);
    cyc(LAT + 3);
    n_tests++; if (irqFlags !== 8'h00) begin n_fail++; $display("FAIL rise_base: got %h exp 00", irqFlags); end
    ext_val = 8'h01;
    cyc(LAT - 1);
    n_tests++; if (inData !== 8'h00) begin n_fail++; $display("FAIL rise_early: got %h exp 00", inData); end
    cyc(1);
    n_tests++; if (inData !== 8'h01) begin n_fail++; $display("FAIL rise_indata: got %h exp 01", inData); end
    n_tests++; if (irqFlags !== 8'h00) begin n_fail++; $display("FAIL rise_flag_early: got %h exp 00", irqFlags); end
    cyc(1);
    n_tests++; if (irqFlags !== 8'h01) begin n_fail++; $display("FAIL rise_flag: got %h exp 01", irqFlags); end
    n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL rise_irq: got %b exp 1", irq); end
    clr(8'h01);
    n_tests++; if (irqFlags !== 8'h00) begin n_fail++; $display("FAIL rise_clr: got %h exp 00", irqFlags); end
    ext_val = 8'h00;
    cyc(LAT + 3);
    n_tests++; if (irqFlags !== 8'h00) begin n_fail++; $display("FAIL fall_unmasked: got %h exp 00", irqFlags); end
  endtask

  task automatic test_fall_and_both;
    wr_cfg(8'h00, 8'h01);
    ext_val = 8'h01;
    cyc(LAT + 3);
    n_tests++; if (irqFlags !== 8'h00) begin n_fail++; $display("FAIL rise_unmasked: got %h exp 00", irqFlags); end
    ext_val = 8'h00;
    cyc(LAT + 1);
    n_tests++; if (irqFlags !== 8'h01) begin n_fail++; $display("FAIL fall_flag: got %h exp 01", irqFlags); end
    clr(8'h01);
    wr_cfg(8'h01, 8'h01);
    ext_val = 8'h01;
    cyc(LAT + 3);
    n_tests++; if (irqFlags !== 8'h01) begin n_fail++; $display("FAIL both_rise: got %h exp 01", irqFlags); end
    clr(8'h01);
    ext_val = 8'h00;
    cyc(LAT + 3);
    n_tests++; if (irqFlags !== 8'h01) begin n_fail++; $display("FAIL both_fall: got %h exp 01", irqFlags); end
    wr_cfg(8'h00, 8'h00);
    n_tests++; if (irqFlags !== 8'h01) begin n_fail++; $display("FAIL mask_keeps_flag: got %h exp 01", irqFlags); end
    clr(8'h01);
  endtask

  task automatic test_set_beats_clear;
    wr_cfg(8'h01, 8'h00);
    ext_val = 8'h01;
    cyc(LAT + 1);
    n_tests++; if (irqFlags !== 8'h01) begin n_fail++; $display("FAIL sbc_first: got %h exp 01", irqFlags); end
    ext_val = 8'h00;
    cyc(LAT + 3);
    ext_val = 8'h01;
    cyc(LAT);
    ceIrqClr = 1'b1; irqClr = 8'h01;
    @(negedge clk);
    ceIrqClr = 1'b0; irqClr = '0;
    n_tests++; if (irqFlags !== 8'h01) begin n_fail++; $display("FAIL set_beats_clr: got %h exp 01", irqFlags); end
    clr(8'h02);
    n_tests++; if (irqFlags !== 8'h01) begin n_fail++; $display("FAIL clr_other_bit: got %h exp 01", irqFlags); end
    clr(8'h01);
    n_tests++; if (irqFlags !== 8'h00) begin n_fail++; $display("FAIL clr_alone: got %h exp 00", irqFlags); end
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL clr_irq: got %b exp 0", irq); end
  endtask

  task automatic test_prime_and_midreset;
    rst = 1'b1; ext_en = 8'hFF; ext_val = 8'hFF;
    cyc(4);
    n_tests++; if (inData !== 8'h00) begin n_fail++; $display("FAIL rst_hold_indata: got %h exp 00", inData); end
    n_tests++; if (pad !== 8'hFF) begin n_fail++; $display("FAIL rst_hold_pad: got %h exp ff", pad); end
    rst = 1'b0;
    wr_cfg(8'hFF, 8'hFF);
    for (int k = 0; k < LAT + 8; k++) begin
      n_tests++; if (irqFlags !== 8'h00) begin n_fail++; $display("FAIL prime_cyc%0d: got %h exp 00", k, irqFlags); end
      cyc(1);
    end
    n_tests++; if (inData !== 8'hFF) begin n_fail++; $display("FAIL prime_indata: got %h exp ff", inData); end
    wr_out(2'b00, 8'h0F);
    wr_dir(8'h0F);
    ext_en = 8'hF0; ext_val = 8'h70;
    cyc(LAT + 2);
    n_tests++; if (irqFlags !== 8'h80) begin n_fail++; $display("FAIL mid_flag: got %h exp 80", irqFlags); end
    n_tests++; if (pad !== 8'h7F) begin n_fail++; $display("FAIL mid_pad: got %h exp 7f", pad); end
    ext_en = 8'hFF; ext_val = 8'h7F;
    rst = 1'b1;
    cePortDir = 1'b1; portDir = 8'hFF; cePortOut = 1'b1; outOp = 2'b00; portData = 8'hFF;
    ceIrqCfg = 1'b1; irqRise = 8'hFF; irqFall = 8'hFF;
    @(negedge clk);
    cePortDir = 1'b0; cePortOut = 1'b0; ceIrqCfg = 1'b0;
    n_tests++; if (pad !== 8'h7F) begin n_fail++; $display("FAIL midrst_pad: got %h exp 7f", pad); end
    n_tests++; if (inData !== 8'h00) begin n_fail++; $display("FAIL midrst_indata: got %h exp 00", inData); end
    n_tests++; if (irqFlags !== 8'h00) begin n_fail++; $display("FAIL midrst_flags: got %h exp 00", irqFlags); end
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL midrst_irq: got %b exp 0", irq); end
    rst = 1'b0;
    ext_val = 8'h00;
    cyc(1);
    n_tests++; if (pad !== 8'h00) begin n_fail++; $display("FAIL midrst_all_z: got %h exp 00", pad); end
  endtask

`ifdef GPIO_DEBOUNCE_EN
  task automatic test_debounce;
    wr_cfg(8'h02, 8'h00);
    cyc(LAT + 10);
    ext_val = 8'h02;
    cyc(3);
    ext_val = 8'h00;
    for (int k = 0; k < 20; k++) begin
      cyc(1);
      n_tests++; if (inData[1] !== 1'b0) begin n_fail++; $display("FAIL db_glitch_cyc%0d: got %b exp 0", k, inData[1]); end
    end
    n_tests++; if (irqFlags !== 8'h00) begin n_fail++; $display("FAIL db_glitch_flag: got %h exp 00", irqFlags); end
    ext_val = 8'h02;
    cyc(LAT - 1);
    n_tests++; if (inData[1] !== 1'b0) begin n_fail++; $display("FAIL db_early: got %b exp 0", inData[1]); end
    cyc(1);
    n_tests++; if (inData[1] !== 1'b1) begin n_fail++; $display("FAIL db_level: got %b exp 1", inData[1]); end
    cyc(1);
    n_tests++; if (irqFlags !== 8'h02) begin n_fail++; $display("FAIL db_flag: got %h exp 02", irqFlags); end
    cyc(10);
  endtask
`endif

  initial begin
    test_reset();
    test_write_ops();
    test_direction();
    test_rise_irq();
    test_fall_and_both();
    test_set_beats_clear();
    test_prime_and_midreset();
`ifdef GPIO_DEBOUNCE_EN
    test_debounce();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
